// File: rtl/bibi_demux_if.sv
// Handshake/bus bundle for the two-bank digit-pair loader.
// BIBI_DEMUX_DEC_EN adds the dec pulse after inc.
interface bibi_demux_if;
  logic       cc;
  logic       start;
  logic       inc;
`ifdef BIBI_DEMUX_DEC_EN
  logic       dec;
`endif
  logic       nxt;
  logic       abort;
  logic [3:0] Borrow;
  logic [3:0] Borrowf;
  logic [3:0] Borrow1;
  logic [3:0] Borrowf1;
  logic       busy;
  logic       done;

  modport master (
    output cc, start, inc,
`ifdef BIBI_DEMUX_DEC_EN
    output dec,
`endif
    output nxt, abort,
    input  Borrow, Borrowf, Borrow1, Borrowf1, busy, done
  );

  modport slave (
    input  cc, start, inc,
`ifdef BIBI_DEMUX_DEC_EN
    input  dec,
`endif
    input  nxt, abort,
    output Borrow, Borrowf, Borrow1, Borrowf1, busy, done
  );
endinterface

// File: rtl/bibi_demux.sv
// Write side of the two-bank display mux: edits one BCD digit pair per session.
// Optional macro BIBI_DEMUX_DEC_EN enables digit decrement via bus.dec.
module bibi_demux #(
  parameter int ONES_MAX = 9,
  parameter int TENS_MAX = 5
) (
  input  logic         clk,
  input  logic         rst,
  bibi_demux_if.slave  bus
);
  localparam logic [3:0] OMAX = 4'(ONES_MAX);
  localparam logic [3:0] TMAX = 4'(TENS_MAX);

  typedef enum logic [1:0] {IDLE, ED_ONES, ED_TENS, COMMIT} state_t;

  state_t                 state, state_n;
  logic [3:0]             w0, w0_n, w1, w1_n;
  logic                   bnk, bnk_n;
  logic [1:0][1:0][3:0]   bank;   // [bank][0=ones,1=tens]
  logic                   busy_q, done_q;
  logic                   up, dn;

`ifdef BIBI_DEMUX_DEC_EN
  // inc and dec together cancel out
  assign up = bus.inc & ~bus.dec;
  assign dn = bus.dec & ~bus.inc;
`else
  assign up = bus.inc;
  assign dn = 1'b0;
`endif

  function automatic logic [3:0] step_dig(input logic [3:0] v, input logic [3:0] mx,
                                          input logic u, input logic d);
    if (u) return (v == mx)    ? 4'd0 : v + 4'd1;
    if (d) return (v == 4'd0)  ? mx   : v - 4'd1;
    return v;
  endfunction

  always_comb begin
    state_n = state;
    w0_n    = w0;
    w1_n    = w1;
    bnk_n   = bnk;
    case (state)
      IDLE: if (bus.start) begin
        bnk_n   = bus.cc;
        w0_n    = bank[bus.cc][0];
        w1_n    = bank[bus.cc][1];
        state_n = ED_ONES;
      end
      ED_ONES: if (bus.abort) state_n = IDLE;
               else begin
                 w0_n = step_dig(w0, OMAX, up, dn);
                 if (bus.nxt) state_n = ED_TENS;
               end
      ED_TENS: if (bus.abort) state_n = IDLE;
               else begin
                 w1_n = step_dig(w1, TMAX, up, dn);
                 if (bus.nxt) state_n = COMMIT;
               end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      w0     <= '0;
      w1     <= '0;
      bnk    <= 1'b0;
      bank   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      w0     <= w0_n;
      w1     <= w1_n;
      bnk    <= bnk_n;
      busy_q <= (state_n != IDLE);
      done_q <= (state == COMMIT);
      // banks only change here, so the edit in progress never shows on the outputs
      if (state == COMMIT) bank[bnk] <= {w1, w0};
    end
  end

  assign bus.Borrow   = bank[0][0];
  assign bus.Borrowf  = bank[0][1];
  assign bus.Borrow1  = bank[1][0];
  assign bus.Borrowf1 = bank[1][1];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_bibi_demux.sv
// Directed and randomized bench for bibi_demux against a bank/digit reference model.
module tb_bibi_demux;
  localparam int OM = 9;
  localparam int TM = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bibi_demux_if bus ();
  bibi_demux #(.ONES_MAX(OM), .TENS_MAX(TM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  // reference model: banks, working pair, edit phase (0 idle,1 ones,2 tens,3 commit)
  int mb[2][2];
  int mw[2];
  int mode;
  int mbnk;
  bit mdone;

  function automatic int bump(int v, int mx, bit u, bit d);
    if (u && !d) return (v + 1) % (mx + 1);
    if (d && !u) return (v + mx) % (mx + 1);
    return v;
  endfunction

  task automatic step(bit r, bit s, bit c, bit i, bit d, bit n, bit a);
    @(negedge clk);
    rst = r; bus.start = s; bus.cc = c; bus.inc = i; bus.nxt = n; bus.abort = a;
`ifdef BIBI_DEMUX_DEC_EN
    bus.dec = d;
`else
    d = 1'b0;
`endif
    @(posedge clk);
    #1;
    mdone = 1'b0;
    if (r) begin
      for (int b = 0; b < 2; b++) begin mb[b][0] = 0; mb[b][1] = 0; end
      mw[0] = 0; mw[1] = 0; mode = 0; mbnk = 0;
    end else begin
      case (mode)
        0: if (s) begin
             mbnk = c; mw[0] = mb[c][0]; mw[1] = mb[c][1]; mode = 1;
           end
        1, 2: if (a) mode = 0;
              else begin
                mw[mode-1] = bump(mw[mode-1], (mode == 1) ? OM : TM, i, d);
                if (n) mode = mode + 1;
              end
        default: begin
          mb[mbnk][0] = mw[0]; mb[mbnk][1] = mw[1]; mode = 0; mdone = 1'b1;
        end
      endcase
    end
    rst = 1'b0; bus.start = 1'b0; bus.inc = 1'b0; bus.nxt = 1'b0; bus.abort = 1'b0;
`ifdef BIBI_DEMUX_DEC_EN
    bus.dec = 1'b0;
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [17:0] got;
    step(1, 0, 0, 0, 0, 0, 0);
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== 18'h0) begin nerr++; $display("FAIL reset_state: got %h want 00000", got); end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);
    nvec++;
    if (bus.busy !== 1'b1) begin nerr++; $display("FAIL reset_pre_busy: got %b want 1", bus.busy); end
    step(1, 0, 0, 0, 0, 0, 0);
    idle();
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== 18'h0) begin nerr++; $display("FAIL reset_mid_edit: got %h want 00000", got); end
  endtask

  task automatic test_edit_bank0();
    logic [17:0] got;
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL edit0_in_commit: got %h want 00002", got); end
    idle();
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd3, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL edit0_written: got %h want %h", got, {4'd3, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1}); end
    idle();
    nvec++;
    if (bus.done !== 1'b0) begin nerr++; $display("FAIL edit0_done_once: got %b want 0", bus.done); end
  endtask

  task automatic test_wrap();
    logic [17:0] got;
    step(0, 1, 1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd3, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL wrap_full_cycle: got %h want %h", got, {4'd3, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1}); end
    step(0, 1, 1, 0, 0, 0, 0);
    repeat (11) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (7) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd3, 4'd2, 4'd1, 4'd1, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL wrap_past_max: got %h want %h", got, {4'd3, 4'd2, 4'd1, 4'd1, 1'b0, 1'b1}); end
  endtask

  task automatic test_abort();
    logic [17:0] got;
    step(0, 1, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd3, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL abort_discard: got %h want %h", got, {4'd3, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0}); end
    idle();
    nvec++;
    if (bus.done !== 1'b0) begin nerr++; $display("FAIL abort_no_done: got %b want 0", bus.done); end
  endtask

  task automatic test_latch_priority();
    logic [17:0] got;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);   // cc flips and start re-pulses mid-edit
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    idle();
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd4, 4'd2, 4'd1, 4'd1, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL latch_bank: got %h want %h", got, {4'd4, 4'd2, 4'd1, 4'd1, 1'b0, 1'b1}); end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd5, 4'd2, 4'd1, 4'd1, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL inc_nxt_same: got %h want %h", got, {4'd5, 4'd2, 4'd1, 4'd1, 1'b0, 1'b1}); end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd5, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL inc_abort_same: got %h want %h", got, {4'd5, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0}); end
  endtask

`ifdef BIBI_DEMUX_DEC_EN
  task automatic test_dec();
    logic [17:0] got;
    step(0, 1, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    got = {bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done};
    nvec++;
    if (got !== {4'd5, 4'd2, 4'd9, 4'd5, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL dec_wrap: got %h want %h", got, {4'd5, 4'd2, 4'd9, 4'd5, 1'b0, 1'b1}); end
  endtask
`endif

  task automatic test_random();
    bit r, s, c, i, d, n, a;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      c = $urandom_range(0, 1);
      i = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 3) == 0);
      n = ($urandom_range(0, 4) == 0);
      a = ($urandom_range(0, 19) == 0);
      step(r, s, c, i, d, n, a);
      nvec++;
      if (bus.Borrow !== 4'(mb[0][0]) || bus.Borrowf !== 4'(mb[0][1]) ||
          bus.Borrow1 !== 4'(mb[1][0]) || bus.Borrowf1 !== 4'(mb[1][1]) ||
          bus.busy !== (mode != 0) || bus.done !== mdone) begin
        nerr++;
        $display("FAIL random[%0d]: got %0d/%0d %0d/%0d busy=%b done=%b want %0d/%0d %0d/%0d busy=%b done=%b",
                 k, bus.Borrow, bus.Borrowf, bus.Borrow1, bus.Borrowf1, bus.busy, bus.done,
                 mb[0][0], mb[0][1], mb[1][0], mb[1][1], (mode != 0), mdone);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.cc = 1'b0; bus.start = 1'b0; bus.inc = 1'b0; bus.nxt = 1'b0; bus.abort = 1'b0;
`ifdef BIBI_DEMUX_DEC_EN
    bus.dec = 1'b0;
`endif
    test_reset();
    test_edit_bank0();
    test_wrap();
    test_abort();
    test_latch_priority();
`ifdef BIBI_DEMUX_DEC_EN
    test_dec();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/bibi_demux.md
Name: bibi_demux

Overview:
- Digit-pair editor/loader: the write side of the two-bank display mux.
- Holds two BCD digit-pair banks, bank 0 (Borrow/Borrowf) and bank 1 (Borrow1/Borrowf1). These outputs feed the display mux inputs of the same names.
- User button pulses edit one bank at a time through a small FSM. The edited bank is written back atomically on commit.
- Bank select uses the same cc convention as the mux: cc=0 selects bank 0, cc=1 selects bank 1.

Parameters:
- ONES_MAX, 9, highest value of the ones digit before wrap to 0.
- TENS_MAX, 5, highest value of the tens digit before wrap to 0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- cc  input  1  bank select, sampled only when an edit starts: 0 = bank 0, 1 = bank 1.
- start  input  1  single-cycle pulse; begin editing the selected bank.
- inc  input  1  single-cycle pulse; increment the digit under edit.
- nxt  input  1  single-cycle pulse; advance to the next digit, or commit.
- abort  input  1  single-cycle pulse; discard the edit.
- Borrow  output  4  bank 0 ones digit.
- Borrowf  output  4  bank 0 tens digit.
- Borrow1  output  4  bank 1 ones digit.
- Borrowf1  output  4  bank 1 tens digit.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse in the cycle after a bank write.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; all four bank outputs, working registers w0/w1 and the bank latch go to 0.
  - busy=0, done=0.
  - Reset during an edit discards the edit; neither bank is written.
- FSM states: IDLE, ED_ONES, ED_TENS, COMMIT. Registered outputs only.
- IDLE:
  - On start, latch bnk=cc, and copy the selected bank into the working registers (w0=ones, w1=tens).
  - Go to ED_ONES; busy=1 from the next cycle.
  - inc, nxt and abort are ignored in IDLE.
- ED_ONES:
  - inc: w0 = (w0==ONES_MAX) ? 0 : w0+1.
  - nxt: go to ED_TENS.
- ED_TENS:
  - inc: w1 = (w1==TENS_MAX) ? 0 : w1+1.
  - nxt: go to COMMIT.
- COMMIT (exactly one cycle):
  - Write w0/w1 into bank bnk; the other bank is untouched.
  - Go to IDLE. done=1 in the following cycle, coincident with busy=0.
  - Write-to-visible-output latency: the updated bank appears on its outputs in the cycle after COMMIT.
- abort in ED_ONES or ED_TENS: go to IDLE with no write and no done pulse. abort has highest priority over inc and nxt in the same cycle.
- inc and nxt in the same cycle: the increment applies to the current digit, then the state advances.
- start while busy: ignored. cc changes while busy: ignored, because the bank is latched at start.
- Bank outputs are stable and unchanged throughout an edit; the working values are not visible on them.
- Digit arithmetic:
  - 4-bit unsigned, wrap only at the MAX parameters.
  - Bank registers are written only from w0/w1, so out-of-range values cannot occur after reset.

Optional Feature:
- Macro: BIBI_DEMUX_DEC_EN.
- Defined:
  - Adds input port dec (1 bit, single-cycle pulse) after inc.
  - dec in ED_ONES: w0 = (w0==0) ? ONES_MAX : w0-1. dec in ED_TENS: the same rule on w1 with TENS_MAX.
  - inc and dec in the same cycle: no change to the digit.
  - Priority: abort > (inc/dec) > nxt ordering as above.
- Not defined: port dec does not exist, and the digits can only increment.

Test Plan:
- Reset → all four bank outputs 0, busy=0, done=0.
  - Then assert rst mid-edit in ED_TENS with w1=3 → banks remain 0 and FSM returns to IDLE.
- Edit bank 0:
  - Stimulus: cc=0, start, 3×inc, nxt, 2×inc, nxt.
  - Response: Borrow=3, Borrowf=2, and bank 1 stays 0. done pulses once, 1 cycle after COMMIT, with busy=0 in the same cycle.
- Wrap with defaults:
  - Stimulus: cc=1, start, 10×inc on ones, nxt, 6×inc on tens, nxt.
  - Response: Borrow1=0, Borrowf1=0.
  - Then 11×inc on ones and 7×inc on tens → Borrow1=1, Borrowf1=1.
- Abort:
  - Precondition: bank 0 = 3/2.
  - Stimulus: start with cc=0, 4×inc, abort.
  - Response: Borrow=3, Borrowf=2 unchanged; no done pulse; busy=0 the next cycle.
- Latching and priority:
  - cc toggles 0→1 during an edit started with cc=0 → commit writes bank 0 only.
  - inc+nxt in the same cycle in ED_ONES (w0=4) → w0=5 and the state is ED_TENS.
  - inc+abort in the same cycle → no change, IDLE.
- With BIBI_DEMUX_DEC_EN defined:
  - dec on ones=0 → 9; dec on tens=0 → 5.
  - inc+dec in the same cycle → digit unchanged.
